// File: rtl/bcd_disp_pkg.sv
// Shared constants for the BCD result display driver: glyph codes,
// digit positions and the anode helpers used by the scan logic.
package bcd_disp_pkg;

    // Active-low segment codes, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_R     = 7'b0101111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Digit positions on the 4-digit display (bit index into anode)
    localparam logic [1:0] DIG_ONES  = 2'd0;
    localparam logic [1:0] DIG_TENS  = 2'd1;
    localparam logic [1:0] DIG_HUNDS = 2'd2;
    localparam logic [1:0] DIG_SIGN  = 2'd3;

    localparam logic [3:0] ANODE_OFF = 4'b1111;

    // A captured result: error flag, sign and three BCD nibbles
    typedef struct packed {
        logic        err;
        logic        neg;
        logic [11:0] bcd;
    } disp_val_t;

    // Active-low one-hot enable for the selected digit
    function automatic logic [3:0] anode_sel(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/bcd_seg_decode.sv
// Nibble to seven-segment decoder. Non-decimal nibbles show 'E' so a
// corrupted result is visible rather than silently mis-rendered.
module bcd_seg_decode
    import bcd_disp_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       blank,
    output logic [6:0] segment
);

    // Pure lookup; blank wins over the nibble value
    always_comb begin
        segment = SEG_E;
        if (blank) begin
            segment = SEG_BLANK;
        end else begin
            case (nibble)
                4'd0:    segment = SEG_0;
                4'd1:    segment = SEG_1;
                4'd2:    segment = SEG_2;
                4'd3:    segment = SEG_3;
                4'd4:    segment = SEG_4;
                4'd5:    segment = SEG_5;
                4'd6:    segment = SEG_6;
                4'd7:    segment = SEG_7;
                4'd8:    segment = SEG_8;
                4'd9:    segment = SEG_9;
                default: segment = SEG_E;
            endcase
        end
    end

endmodule

// File: rtl/bcd_display_scan.sv
// Multiplexed 4-digit display driver for the signed 3-digit BCD result.
// Results are staged in a pending register and promoted to the display
// register only at the frame boundary so a frame never shows a mix of
// two values. Outputs are registered one cycle behind the scan state,
// and every slot starts with one all-off cycle to avoid ghosting.
module bcd_display_scan
    import bcd_disp_pkg::*;
#(
    parameter int REFRESH_CLKS = 100000,
    parameter int CNT_W        = 17
) (
    input  logic        clk,
    input  logic        resetPulse,
    input  logic        load,
    input  logic [11:0] bcdIn,
    input  logic        negIn,
    input  logic        errIn,
    output logic [3:0]  anode,
    output logic [6:0]  segment,
    output logic        frameStart
);

    logic [CNT_W-1:0] ref_cnt;
    logic [1:0]       digit_idx;
    logic             slot_end;
    logic             frame_end;
    logic             slot_first;

    disp_val_t        in_val;
    disp_val_t        pend_val;
    disp_val_t        disp_val;
    logic             pend_valid;

    logic [3:0]       nib_h;
    logic [3:0]       nib_t;
    logic [3:0]       nib_o;
    logic             h_nz;
    logic             t_nz;
    logic             o_nz;

    logic [3:0]       dec_nibble;
    logic             dec_blank;
    logic [6:0]       dec_seg;
    logic [6:0]       glyph;

    assign slot_end   = (ref_cnt == CNT_W'(REFRESH_CLKS - 1));
    assign frame_end  = slot_end && (digit_idx == DIG_SIGN);
    assign slot_first = (ref_cnt == '0);

    assign in_val = '{err: errIn, neg: negIn, bcd: bcdIn};

    // Slot timer and digit pointer; digit advances when the slot expires
    always_ff @(posedge clk) begin
        if (resetPulse) begin
            ref_cnt   <= '0;
            digit_idx <= DIG_ONES;
        end else if (slot_end) begin
            ref_cnt   <= '0;
            digit_idx <= digit_idx + 2'd1;
        end else begin
            ref_cnt   <= ref_cnt + 1'b1;
        end
    end

    // Pending/display staging; a load landing on the boundary bypasses pending
    always_ff @(posedge clk) begin
        if (resetPulse) begin
            pend_val   <= '0;
            disp_val   <= '0;
            pend_valid <= 1'b0;
        end else if (frame_end) begin
            pend_valid <= 1'b0;
            if (load) begin
                disp_val <= in_val;
            end else if (pend_valid) begin
                disp_val <= pend_val;
            end
        end else if (load) begin
            pend_val   <= in_val;
            pend_valid <= 1'b1;
        end
    end

    assign nib_h = disp_val.bcd[11:8];
    assign nib_t = disp_val.bcd[7:4];
    assign nib_o = disp_val.bcd[3:0];

    // Non-decimal nibbles are non-zero here, so they are never blanked
    assign h_nz = (nib_h != 4'd0);
    assign t_nz = (nib_t != 4'd0);
    assign o_nz = (nib_o != 4'd0);

    // Select the nibble and leading-zero blank for the current digit
    always_comb begin
        dec_nibble = 4'd0;
        dec_blank  = 1'b1;
        case (digit_idx)
            DIG_ONES: begin
                dec_nibble = nib_o;
                dec_blank  = 1'b0;
            end
            DIG_TENS: begin
                dec_nibble = nib_t;
                dec_blank  = !h_nz && !t_nz;
            end
            DIG_HUNDS: begin
                dec_nibble = nib_h;
                dec_blank  = !h_nz;
            end
            default: begin
                dec_nibble = 4'd0;
                dec_blank  = 1'b1;
            end
        endcase
    end

    bcd_seg_decode u_seg_decode (
        .nibble  (dec_nibble),
        .blank   (dec_blank),
        .segment (dec_seg)
    );

    // Final glyph: error text, sign digit, or the decoded value digit
    always_comb begin
        glyph = SEG_BLANK;
        if (disp_val.err) begin
            case (digit_idx)
                DIG_SIGN:  glyph = SEG_E;
                DIG_HUNDS: glyph = SEG_R;
                DIG_TENS:  glyph = SEG_R;
                default:   glyph = SEG_BLANK;
            endcase
        end else if (digit_idx == DIG_SIGN) begin
            // Negative zero is shown unsigned
            glyph = (disp_val.neg && (h_nz || t_nz || o_nz)) ? SEG_MINUS : SEG_BLANK;
        end else begin
            glyph = dec_seg;
        end
    end

    // Registered outputs with an all-off first cycle in every slot
    always_ff @(posedge clk) begin
        if (resetPulse) begin
            anode      <= ANODE_OFF;
            segment    <= SEG_BLANK;
            frameStart <= 1'b0;
        end else begin
            frameStart <= slot_first && (digit_idx == DIG_ONES);
            if (slot_first) begin
                anode   <= ANODE_OFF;
                segment <= SEG_BLANK;
            end else begin
                anode   <= anode_sel(digit_idx);
                segment <= glyph;
            end
        end
    end

endmodule

// File: tb/tb_bcd_display_scan.sv
// Directed bench for bcd_display_scan with a 4-clock slot (16-clock frame).
module tb_bcd_display_scan;

    localparam logic [6:0] G0 = 7'b1000000;
    localparam logic [6:0] G1 = 7'b1111001;
    localparam logic [6:0] G2 = 7'b0100100;
    localparam logic [6:0] G3 = 7'b0110000;
    localparam logic [6:0] G4 = 7'b0011001;
    localparam logic [6:0] G5 = 7'b0010010;
    localparam logic [6:0] G6 = 7'b0000010;
    localparam logic [6:0] G7 = 7'b1111000;
    localparam logic [6:0] G8 = 7'b0000000;
    localparam logic [6:0] G9 = 7'b0010000;
    localparam logic [6:0] GM = 7'b0111111;
    localparam logic [6:0] GE = 7'b0000110;
    localparam logic [6:0] GR = 7'b0101111;
    localparam logic [6:0] GB = 7'b1111111;

    localparam logic [27:0] SHOW_ZERO = {GB, GB, GB, G0};

    logic        clk = 1'b0;
    logic        resetPulse;
    logic        load;
    logic [11:0] bcdIn;
    logic        negIn;
    logic        errIn;
    logic [3:0]  anode;
    logic [6:0]  segment;
    logic        frameStart;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic [11:0] bcd;
        logic        neg;
        logic        err;
        int          lp;
        logic [27:0] exp;   // {digit3, digit2, digit1, digit0}
    } vec_t;

    vec_t vecs [12];

    always #5 clk = ~clk;

    bcd_display_scan #(
        .REFRESH_CLKS (4),
        .CNT_W        (3)
    ) dut (
        .clk        (clk),
        .resetPulse (resetPulse),
        .load       (load),
        .bcdIn      (bcdIn),
        .negIn      (negIn),
        .errIn      (errIn),
        .anode      (anode),
        .segment    (segment),
        .frameStart (frameStart)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [6:0] act, input logic [6:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b required=%b", name, act, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " anode"}, {3'b000, anode}, 7'b0001111);
        chk({tag, " segment"}, segment, GB);
        chk({tag, " frameStart"}, {6'b0, frameStart}, 7'd0);
    endtask

    // One 16-cycle frame starting at a frame boundary; up to three loads
    // (value packed as {err,neg,bcd}) issued at the given cycle offsets.
    task automatic run_frame(input string tag, input logic [27:0] exp,
                             input int lpa, input logic [13:0] va,
                             input int lpb, input logic [13:0] vb,
                             input int lpc, input logic [13:0] vc);
        logic [3:0][6:0] glyphs;
        glyphs = exp;
        for (int i = 0; i < 16; i++) begin
            int         d;
            logic       ghost;
            logic [3:0] ea;
            logic [6:0] es;
            if (i == lpa) begin {errIn, negIn, bcdIn} = va; load = 1'b1; end
            if (i == lpb) begin {errIn, negIn, bcdIn} = vb; load = 1'b1; end
            if (i == lpc) begin {errIn, negIn, bcdIn} = vc; load = 1'b1; end
            tick;
            load  = 1'b0;
            d     = i / 4;
            ghost = (i % 4 == 0);
            ea    = ghost ? 4'b1111 : ~(4'b0001 << d);
            es    = ghost ? GB : glyphs[d];
            chk($sformatf("%s anode c%0d", tag, i), {3'b000, anode}, {3'b000, ea});
            chk($sformatf("%s segment c%0d", tag, i), segment, es);
            chk($sformatf("%s frameStart c%0d", tag, i), {6'b0, frameStart},
                {6'b0, (i == 0)});
        end
    endtask

    initial begin
        logic [27:0] prev;

        vecs[0]  = '{"neg042",  12'h042, 1'b1, 1'b0,  6, {GM, GB, G4, G2}};
        vecs[1]  = '{"negzero", 12'h000, 1'b1, 1'b0,  3, {GB, GB, GB, G0}};
        vecs[2]  = '{"err999",  12'h999, 1'b0, 1'b1, 10, {GE, GR, GR, GB}};
        vecs[3]  = '{"pos105",  12'h105, 1'b0, 1'b0,  0, {GB, G1, G0, G5}};
        vecs[4]  = '{"bnd007",  12'h007, 1'b1, 1'b0, 15, {GM, GB, GB, G7}};
        vecs[5]  = '{"tensA",   12'h0A3, 1'b0, 1'b0,  7, {GB, GB, GE, G3}};
        vecs[6]  = '{"hundA",   12'hA00, 1'b1, 1'b0, 12, {GM, GE, G0, G0}};
        vecs[7]  = '{"onesF",   12'h00F, 1'b1, 1'b0,  1, {GM, GB, GB, GE}};
        vecs[8]  = '{"pos999",  12'h999, 1'b0, 1'b0,  9, {GB, G9, G9, G9}};
        vecs[9]  = '{"neg500",  12'h500, 1'b1, 1'b0,  5, {GM, G5, G0, G0}};
        vecs[10] = '{"pos608",  12'h608, 1'b0, 1'b0, 13, {GB, G6, G0, G8}};
        vecs[11] = '{"errneg0", 12'h000, 1'b1, 1'b1,  4, {GE, GR, GR, GB}};

        resetPulse = 1'b1;
        load       = 1'b0;
        bcdIn      = 12'h000;
        negIn      = 1'b0;
        errIn      = 1'b0;

        for (int i = 0; i < 3; i++) begin
            tick;
            chk_reset_outputs($sformatf("reset%0d", i));
        end
        resetPulse = 1'b0;

        run_frame("idle0", SHOW_ZERO, -1, '0, -1, '0, -1, '0);
        run_frame("idle1", SHOW_ZERO, -1, '0, -1, '0, -1, '0);

        // Each frame loads a value and must still show the previous one
        prev = SHOW_ZERO;
        for (int k = 0; k < 12; k++) begin
            run_frame({vecs[k].name, "_cur"}, prev, vecs[k].lp,
                      {vecs[k].err, vecs[k].neg, vecs[k].bcd}, -1, '0, -1, '0);
            prev = vecs[k].exp;
        end
        run_frame("hold", prev, -1, '0, -1, '0, -1, '0);

        // Two mid-frame loads, then one in the boundary cycle: last wins
        run_frame("multi_cur", prev, 2, {2'b00, 12'h123}, 8, {2'b00, 12'h456},
                  15, {2'b00, 12'h789});
        run_frame("multi_new", {GB, G7, G8, G9}, -1, '0, -1, '0, -1, '0);
        run_frame("multi_hold", {GB, G7, G8, G9}, -1, '0, -1, '0, -1, '0);

        // Reset in the middle of the digit-2 slot with a load pending
        for (int i = 0; i < 10; i++) begin
            if (i == 5) begin
                bcdIn = 12'h321;
                negIn = 1'b1;
                errIn = 1'b0;
                load  = 1'b1;
            end
            tick;
            load = 1'b0;
        end
        resetPulse = 1'b1;
        tick;
        chk_reset_outputs("midreset");
        resetPulse = 1'b0;
        run_frame("post_reset0", SHOW_ZERO, -1, '0, -1, '0, -1, '0);
        run_frame("post_reset1", SHOW_ZERO, -1, '0, -1, '0, -1, '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
